// File: rtl/gf2m_pkg.sv
// Shared constants for the GF(2^M) inverter: the sect163 field and the controller state encoding.
// Pure declarations; no logic, no latency, no handshake.
package gf2m_pkg;
   localparam int              M_163    = 163;
   localparam logic [M_163:0]  POLY_163 = {1'b1, 155'b0, 8'b1100_1001};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/gf2m_inverter_if.sv
// Start/done handshake bundle between an inversion requester and gf2m_inverter.
// No latency of its own; the requester holds off while busy, since extra starts are dropped.
interface gf2m_inverter_if
   import gf2m_pkg::*;
#(
   parameter int M = M_163
);
   logic         start;
   logic [M-1:0] a;
   logic         busy;
   logic         done;
   logic         err;
   logic [M-1:0] result;

   modport master (output start, a, input busy, done, err, result);
   modport slave  (input start, a, output busy, done, err, result);
endinterface

// File: rtl/gf2m_lod.sv
// Leading-one detector: index of the highest set bit of x (0 when x is zero).
// Purely combinational, zero latency, no backpressure.
module gf2m_lod #(
   parameter int W  = 164,
   parameter int IW = $clog2(W)
) (
   input  logic [W-1:0]  x,
   output logic [IW-1:0] idx
);
   always_comb begin
      idx = '0;
      for (int i = 0; i < W; i++) begin
         if (x[i]) idx = i[IW-1:0];
      end
   end
endmodule

// File: rtl/gf2m_inverter.sv
// Binary extended-Euclid inverter over GF(2^M): one step per clock, done at most 4*M+2 cycles after start.
// No backpressure: start is sampled only in IDLE, and any start seen while busy or done is dropped.
module gf2m_inverter
   import gf2m_pkg::*;
#(
   parameter int         M    = M_163,
   parameter logic [M:0] POLY = POLY_163
) (
   input  logic           clk,
   input  logic           rst,
   gf2m_inverter_if.slave io
);
   localparam int           DW    = $clog2(M + 1);
   localparam logic [M-1:0] U_ONE = {{(M-1){1'b0}}, 1'b1};
   localparam logic [M:0]   V_ONE = {{M{1'b0}}, 1'b1};

   logic [1:0]    state;
   logic [M-1:0]  u, g1, g2, result_q;
   logic [M:0]    v;
   logic          err_q;
   logic [DW-1:0] deg_u, deg_v;

   // g/x mod f: bit 0 of g^f is always 0 when g is odd, so only bits M..1 of f matter.
   function automatic logic [M-1:0] div_x(input logic [M-1:0] g);
      return g[0] ? ((g >> 1) ^ POLY[M:1]) : (g >> 1);
   endfunction

   gf2m_lod #(.W(M + 1)) u_lod_u (.x({1'b0, u}), .idx(deg_u));
   gf2m_lod #(.W(M + 1)) u_lod_v (.x(v),         .idx(deg_v));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         u        <= '0;
         v        <= '0;
         g1       <= '0;
         g2       <= '0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (io.start) begin
                  u        <= io.a;
                  v        <= POLY;
                  g1       <= U_ONE;
                  g2       <= '0;
                  result_q <= '0;
                  err_q    <= (io.a == '0);
                  state    <= (io.a == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (u == U_ONE) begin
                  result_q <= g1;
                  state    <= S_DONE;
               end else if (v == V_ONE) begin
                  result_q <= g2;
                  state    <= S_DONE;
               end else if (!u[0]) begin
                  u  <= u >> 1;
                  g1 <= div_x(g1);
               end else if (!v[0]) begin
                  v  <= v >> 1;
                  g2 <= div_x(g2);
               end else if (deg_u > deg_v) begin
                  // deg(v) < deg(u) <= M-1 here, so v[M] is zero and truncation is lossless.
                  u  <= u ^ v[M-1:0];
                  g1 <= g1 ^ g2;
               end else begin
                  v  <= v ^ {1'b0, u};
                  g2 <= g2 ^ g1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign io.busy   = (state == S_RUN);
   assign io.done   = (state == S_DONE);
   assign io.err    = err_q;
   assign io.result = result_q;
endmodule

// File: doc/gf2m_inverter.md
Name: gf2m_inverter

Overview:
Sequential multiplicative inverter over GF(2^M), polynomial basis, using the binary extended Euclidean algorithm. It computes a^-1 mod f(x), with default f = x^163+x^7+x^6+x^3+1. It is the division-side counterpart to the Karatsuba multiplier datapath, and feeds point-arithmetic projective-to-affine conversion. Start/done handshake; one algorithm step per clock.

Parameters:
M, 163, field degree (operand/result width)
POLY, {1'b1, 155'b0, 8'b1100_1001}, reduction polynomial f(x); M+1 bits; bit M and bit 0 must be 1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  M  operand, captured on the accepted start cycle
busy  output  1  high in RUN and DONE-entry transition; low in IDLE
done  output  1  one-cycle pulse when result/err valid
err  output  1  high with done when a==0; held until next accepted start
result  output  M  a^-1 mod f; held from done until next accepted start

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; busy=0, done=0, err=0, result=0.
  - u, v, g1 and g2 are cleared.
  - Reset mid-RUN aborts the computation with no done pulse.
- IDLE, start=1:
  - Load u=a (M bits), v=POLY (M+1 bits), g1=1, g2=0.
  - Clear err and result.
  - If a==0: go to DONE with err=1, result=0.
  - Otherwise go to RUN.
- RUN: one step per cycle, evaluated in priority order:
  1. u==1 -> result=g1, go to DONE.
  2. v==1 -> result=g2, go to DONE.
  3. u[0]==0 -> u=u>>1; g1=g1/x.
  4. v[0]==0 -> v=v>>1; g2=g2/x.
  5. Otherwise, if deg(u) > deg(v): u=u^v, g1=g1^g2. Else: v=v^u, g2=g2^g1.
- Division by x: g/x = g>>1 if g[0]==0, else (g ^ POLY)>>1. The result always fits in M bits.
- deg(): index of the highest set bit, from a leading-one detector over M+1 bits. u is zero-extended to M+1 bits for the comparison.
- Step 5 always produces an even operand, so the next step is a shift.
- Latency:
  - Cycles from the start edge to the done pulse are at most 4*M+2.
  - a==1 finishes in exactly 2 cycles (the load cycle, then one RUN cycle detecting u==1).
  - a==0 gives done on the cycle after the start edge.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE. start is ignored in DONE.
- start while busy or in DONE: ignored, with no effect on the ongoing operation. It is not queued.
- a is don't-care except on the accepted start cycle.
- Back-to-back: start may be re-asserted in the IDLE cycle right after done.
- Precondition: the operand satisfies a < f. Its width M guarantees this.

Decomposition:
- Shared package gf2m_pkg:
  - M_163 = 163 and POLY_163 constant.
  - State enum {IDLE, RUN, DONE}.
- One natural sub-module, gf2m_lod: combinational leading-one detector, parameterized width W, outputs clog2(W)-bit index. Two instances are used, one for u and one for v.
- The divide-by-x logic is a local function, not a module.

Test Plan:
1. M=163, a=1 -> done after 2 cycles, result=1, err=0.
2. M=163, a=2 (x) -> result has bits {162,6,5,2} set, i.e. x^162+x^6+x^5+x^2, err=0.
3. M=163, a=0 -> done one cycle after start, err=1, result=0.
4. M=2 with POLY=3'b111:
   - a=2'b10 -> result=2'b11.
   - a=2'b11 -> result=2'b10.
   - a=2'b01 -> result=2'b01.
5. M=163, 1000 random nonzero a:
   - Golden check: a*result mod f == 1.
   - Latency is at most 654 cycles.
   - done is high for exactly one cycle.
6. Control corner cases:
   - start pulsed mid-RUN with a different a -> ignored; the first operand's inverse is returned.
   - rst asserted mid-RUN -> all outputs 0, no done.
   - A subsequent start then completes correctly.
